// File: rtl/demux_dispatch_ctrl_pkg.sv
// Shared definitions for the demux dispatch controller: FSM encoding, destinations
// and the destination-selection helper.
package demux_dispatch_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PULSE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic DEST_OUT1 = 1'b0;
  localparam logic DEST_OUT2 = 1'b1;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StPulse = ST_PULSE,
    StGap   = ST_GAP
  } state_e;

  // Mode 1 forces the destination from Target; Mode 0 follows the toggle register.
  function automatic logic pick_dest(input logic mode, input logic target, input logic toggle);
    return mode ? target : toggle;
  endfunction

endpackage

// File: rtl/demux_dispatch_ctrl_btn_debounce.sv
// Button conditioning: 2-flop synchronizer, stability counter and a one-cycle
// request pulse on each debounced rising edge.
module demux_dispatch_ctrl_btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic btn_i,
  output logic req_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic            sync1_q, sync2_q;
  logic            deb_q, deb_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            req_q, req_d;

  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync2_q != deb_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
    req_d = deb_d & ~deb_q;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  assign req_o = req_q;

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Dispatch controller: queues debounced button requests and emits timed,
// select-stable enable pulses for the 1-to-2 demultiplexer.
module demux_dispatch_ctrl
  import demux_dispatch_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PULSE_LEN       = 3,
  parameter int unsigned QUEUE_MAX       = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Btn,
  input  logic       Mode,
  input  logic       Target,
  input  logic       Clear,
  output logic       Sel,
  output logic       E,
  output logic       Busy,
  output logic [1:0] Pending,
  output logic       Overflow
);

  localparam int unsigned PcntW = $clog2(PULSE_LEN + 1);

  logic             req;
  state_e           state_q, state_d;
  logic             sel_q, sel_d;
  logic             e_q, e_d;
  logic             tog_q, tog_d;
  logic [PcntW-1:0] pcnt_q, pcnt_d;
  logic [1:0]       pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic             inc, dec;

  demux_dispatch_ctrl_btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .Clk  (Clk),
    .Reset(Reset),
    .btn_i(Btn),
    .req_o(req)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    e_d     = e_q;
    tog_d   = tog_q;
    pcnt_d  = pcnt_q;
    unique case (state_q)
      StIdle: begin
        if (pend_q != 2'd0) begin
          state_d = StPulse;
          sel_d   = pick_dest(Mode, Target, tog_q);
          e_d     = 1'b1;
          pcnt_d  = PcntW'(1);
          if (!Mode) tog_d = ~tog_q;
        end
      end
      StPulse: begin
        if (pcnt_q == PcntW'(PULSE_LEN)) begin
          e_d     = 1'b0;
          state_d = StGap;
        end else begin
          pcnt_d = pcnt_q + PcntW'(1);
        end
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Clear wins over any same-cycle request; an accepted dispatch is never undone.
  always_comb begin
    inc    = req;
    dec    = (state_q == StIdle) && (pend_q != 2'd0);
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (Clear) begin
      pend_d = 2'd0;
      ovf_d  = 1'b0;
    end else if (inc && !dec) begin
      if (pend_q < 2'(QUEUE_MAX)) pend_d = pend_q + 2'd1;
      else                        ovf_d  = 1'b1;
    end else if (dec && !inc) begin
      pend_d = pend_q - 2'd1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      sel_q   <= DEST_OUT1;
      e_q     <= 1'b0;
      tog_q   <= DEST_OUT1;
      pcnt_q  <= '0;
      pend_q  <= 2'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      e_q     <= e_d;
      tog_q   <= tog_d;
      pcnt_q  <= pcnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Sel      = sel_q;
  assign E        = e_q;
  assign Busy     = (state_q != StIdle);
  assign Pending  = pend_q;
  assign Overflow = ovf_q;

endmodule
